// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around mem_port_arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_addr, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between fetch and load/store, data first with a streak limit.
// Optional grant/wait counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int MAX_D_STREAK = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]        stat_i_grants,
  output logic [31:0]        stat_d_grants,
  output logic [31:0]        stat_i_wait
`endif
);

  localparam int              SW         = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [3:0]      LAT        = 4'(MEM_LATENCY);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [SW-1:0] d_streak, d_streak_nx;
  logic          own_d, own_d_nx;
  logic          grant_d, grant_i, done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      d_streak <= '0;
      own_d    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      d_streak <= d_streak_nx;
      own_d    <= own_d_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    d_streak_nx = d_streak;
    own_d_nx    = own_d;
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        // Data wins unless it has already starved a waiting fetch for MAX_D_STREAK grants.
        grant_d = bus.d_req && !(bus.i_req && d_streak == STREAK_MAX);
        grant_i = !grant_d && bus.i_req;
        if (grant_d || grant_i) begin
          state_nx = BUSY;
          cnt_nx   = LAT;
          own_d_nx = grant_d;
        end
        if (grant_d)
          d_streak_nx = bus.i_req ? d_streak + 1'b1 : '0;
        else if (grant_i)
          d_streak_nx = '0;
      end
      BUSY: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A reset cycle neither accepts new work nor completes the access in flight.
    if (reset) begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      done    = 1'b0;
    end
  end

  assign bus.i_gnt    = grant_i;
  assign bus.d_gnt    = grant_d;
  assign bus.i_rvalid = done && !own_d;
  assign bus.d_rvalid = done && own_d;
  assign bus.i_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;
  assign bus.m_req    = grant_d || grant_i;
  assign bus.m_we     = grant_d && bus.d_we;
  assign bus.m_addr   = grant_d ? bus.d_addr : (grant_i ? bus.i_addr : 32'd0);
  assign bus.m_wdata  = grant_d ? bus.d_wdata : 32'd0;
  assign bus.busy     = (state == BUSY);

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_i_grants <= '0;
      stat_d_grants <= '0;
      stat_i_wait   <= '0;
    end else begin
      if (grant_i)               stat_i_grants <= stat_i_grants + 32'd1;
      if (grant_d)               stat_d_grants <= stat_d_grants + 32'd1;
      if (bus.i_req && !grant_i) stat_i_wait   <= stat_i_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus random traffic for mem_port_arbiter, checked every cycle
// against a transaction-level model (completion time, owner, streak count).
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter_if bus1();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] s_ig, s_dg, s_iw, s1_ig, s1_dg, s1_iw;
`endif

  mem_port_arbiter #(.MEM_LATENCY(LAT), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef MEM_ARB_STATS_EN
    , .stat_i_grants(s_ig), .stat_d_grants(s_dg), .stat_i_wait(s_iw)
`endif
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .MAX_D_STREAK(MAXS)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
`ifdef MEM_ARB_STATS_EN
    , .stat_i_grants(s1_ig), .stat_d_grants(s1_dg), .stat_i_wait(s1_iw)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: an access is outstanding until its completion cycle.
  bit          m_out = 1'b0;
  int          m_done = 0;
  bit          m_own_d = 1'b0;
  int          m_streak = 0;
  int          cyc = 0;
  bit          last_gi = 1'b0;
  bit          last_gd = 1'b0;
  logic [31:0] n_ig = '0, n_dg = '0, n_iw = '0;
  string       glog = "";
  bit          t6 = 1'b0;
  bit          e1_gnt = 1'b0;
  bit          e1_rv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chks(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    bit gd, gi, rv;
    logic [31:0] ea, ew;
    @(negedge clk);
    gd = 1'b0; gi = 1'b0; rv = 1'b0;
    if (!reset) begin
      if (!m_out) begin
        gd = bus.d_req && !(bus.i_req && m_streak == MAXS);
        gi = !gd && bus.i_req;
      end else begin
        rv = (cyc == m_done);
      end
    end
    ea = gd ? bus.d_addr : (gi ? bus.i_addr : 32'd0);
    ew = gd ? bus.d_wdata : 32'd0;
    chk1("i_gnt", bus.i_gnt, gi);
    chk1("d_gnt", bus.d_gnt, gd);
    chk1("m_req", bus.m_req, gd | gi);
    chk1("m_we", bus.m_we, gd & bus.d_we);
    chk("m_addr", bus.m_addr, ea);
    chk("m_wdata", bus.m_wdata, ew);
    chk1("i_rvalid", bus.i_rvalid, rv & !m_own_d);
    chk1("d_rvalid", bus.d_rvalid, rv & m_own_d);
    chk1("busy", bus.busy, m_out);
    chk("i_rdata", bus.i_rdata, bus.m_rdata);
    chk("d_rdata", bus.d_rdata, bus.m_rdata);
`ifdef MEM_ARB_STATS_EN
    chk("stat_i_grants", s_ig, n_ig);
    chk("stat_d_grants", s_dg, n_dg);
    chk("stat_i_wait", s_iw, n_iw);
`endif
    if (t6) begin
      chk1("lat1_i_gnt", bus1.i_gnt, e1_gnt);
      chk1("lat1_i_rvalid", bus1.i_rvalid, e1_rv);
    end
    if (bus.d_gnt) glog = {glog, "D"};
    if (bus.i_gnt) glog = {glog, "I"};
    if (reset) begin
      m_out = 1'b0; m_streak = 0;
      n_ig = '0; n_dg = '0; n_iw = '0;
    end else begin
      if (bus.i_req && !gi) n_iw++;
      if (gd) begin
        m_out = 1'b1; m_done = cyc + LAT; m_own_d = 1'b1;
        m_streak = bus.i_req ? m_streak + 1 : 0;
        n_dg++;
      end
      if (gi) begin
        m_out = 1'b1; m_done = cyc + LAT; m_own_d = 1'b0;
        m_streak = 0;
        n_ig++;
      end
      if (rv) m_out = 1'b0;
    end
    last_gi = gi; last_gd = gd;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.m_rdata = 0;
    bus1.i_req = 0; bus1.i_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = 0; bus1.d_wdata = 0; bus1.m_rdata = 0;

    // Reset state
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;

    // Latency-1 back-to-back fetches: grants on even cycles, rvalid on odd ones
    t6 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus1.i_req   = (k <= 4);
      bus1.i_addr  = 32'h200 + 32'(k);
      bus1.m_rdata = 32'(k);
      e1_gnt = (k % 2 == 0) && (k <= 4);
      e1_rv  = (k % 2 == 1);
      cycle();
    end
    t6 = 1'b0;
    bus1.i_req = 1'b0;
`ifdef MEM_ARB_STATS_EN
    chk("lat1_stat_i_grants", s1_ig, 32'd3);
    chk("lat1_stat_i_wait", s1_iw, 32'd2);
    chk("lat1_stat_d_grants", s1_dg, 32'd0);
`endif

    // Fetch held from cycle 0: grants at 0 and 3, data 0x13 at 2
    glog = "";
    bus.i_req = 1'b1; bus.i_addr = 32'h100; bus.m_rdata = 32'h13;
    for (int k = 0; k < 4; k++) cycle();
    bus.i_req = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    chks("fetch_order", glog, "II");

    // Simultaneous load and fetch: data first, fetch 3 cycles later
    glog = "";
    bus.i_req = 1'b1; bus.i_addr = 32'h104;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400;
    for (int k = 0; k < 7; k++) begin
      cycle();
      if (last_gd) bus.d_req = 1'b0;
      if (last_gi) bus.i_req = 1'b0;
    end
    chks("load_then_fetch", glog, "DI");

    // Store with write data and ack
    glog = "";
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h404; bus.d_wdata = 32'hDEADBEEF;
    cycle();
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    chks("store", glog, "D");

    // Streak limiter with both ports held continuously
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    glog = "";
    bus.i_req = 1'b1; bus.i_addr = 32'h180;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h480;
    for (int k = 0; k < 30; k++) cycle();
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    chks("streak_order", glog, "DDDDIDDDDI");

    // Reset during a load: no d_rvalid, a fresh fetch is granted right after
    glog = "";
    bus.d_req = 1'b1; bus.d_addr = 32'h500;
    cycle();
    bus.d_req = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h1C0;
    cycle();
    bus.i_req = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    chks("reset_mid_access", glog, "DI");

    // Random traffic with occasional abandoned requests and resets
    for (int n = 0; n < 400; n++) begin
      if (bus.i_req && last_gi) bus.i_req = 1'b0;
      else if (!bus.i_req) begin
        bus.i_req = 1'($urandom_range(0, 1));
        bus.i_addr = $urandom;
      end else if ($urandom_range(0, 15) == 0) bus.i_req = 1'b0;
      if (bus.d_req && last_gd) bus.d_req = 1'b0;
      else if (!bus.d_req) begin
        bus.d_req = 1'($urandom_range(0, 1));
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = $urandom;
        bus.d_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) bus.d_req = 1'b0;
      bus.m_rdata = $urandom;
      reset = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency memory between the pipeline's instruction-fetch port and its load/store port.
- Accepts one request at a time over a req/gnt/rvalid handshake and drives the memory with the winner's address and write data.
- Returns read data, or a write acknowledge, to the owning port after MEM_LATENCY cycles.
- Data accesses have priority; a streak limiter prevents data traffic from starving instruction fetch.

Parameters:
MEM_LATENCY, 2, cycles from memory issue to valid m_rdata; legal range 1..15.
MAX_D_STREAK, 4, maximum consecutive data grants while i_req is pending before fetch is forced; must be >=1.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
i_req  in  1  fetch request; held with i_addr until i_gnt
i_addr  in  32  fetch byte address
i_gnt  out  1  fetch request accepted this cycle
i_rvalid  out  1  one-cycle pulse, i_rdata valid
i_rdata  out  32  fetch data
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
d_we  in  1  1=store, 0=load
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledge
d_rdata  out  32  load data
m_req  out  1  memory access strobe, one cycle per access
m_we  out  1  memory write enable, qualified by m_req
m_addr  out  32  memory address
m_wdata  out  32  memory write data
m_rdata  in  32  memory read data, valid MEM_LATENCY cycles after m_req
busy  out  1  access outstanding

Behaviour:
- FSM states: IDLE, BUSY. A 4-bit latency counter cnt and a streak counter d_streak (width clog2(MAX_D_STREAK+1)).
- Grant, IDLE only, combinational in cycle T:
  - d_req && !(i_req && d_streak==MAX_D_STREAK) -> grant D.
  - Else if i_req -> grant I.
- Grant cycle effects:
  - Winner's x_gnt=1 and m_req=1.
  - m_we = d_we for D and 0 for I.
  - m_addr and m_wdata come from the winner; m_wdata=0 for I.
  - Owner is latched, cnt<=MEM_LATENCY, state<=BUSY.
- Outside a grant cycle, m_req, m_we, m_addr and m_wdata are 0.
- BUSY:
  - cnt decrements each cycle.
  - In the cycle where cnt==1 (cycle T+MEM_LATENCY), the owner's x_rvalid=1 and state<=IDLE.
  - No grant is possible in any BUSY cycle. The earliest next grant is T+MEM_LATENCY+1, so one access completes per MEM_LATENCY+1 cycles.
- i_rdata and d_rdata both equal m_rdata at all times; only x_rvalid qualifies them. Store acks also pulse d_rvalid, with d_rdata don't-care.
- busy=1 exactly when state==BUSY.
- Streak counter, updated on grants only:
  - D grant with i_req=1 -> d_streak+1.
  - D grant with i_req=0 -> 0.
  - I grant -> 0.
- Requests arriving while BUSY are not acknowledged; the requester keeps holding. A req dropped before its gnt is legal and forgotten.
- The same port may re-request in the cycle after its rvalid.
- Reset, including mid-access: state=IDLE, cnt=0, d_streak=0. All outputs are 0 in the cycle after reset is sampled. An outstanding access produces no rvalid.

Optional Feature:
MEM_ARB_STATS_EN
- Defined: adds 32-bit outputs stat_i_grants, stat_d_grants and stat_i_wait.
  - stat_i_grants and stat_d_grants count grants.
  - stat_i_wait counts cycles with i_req=1 and i_gnt=0.
  - All three clear on reset and wrap modulo 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. MEM_LATENCY=2, i_req held from cycle 0, addr 0x100, m_rdata=0x00000013 in cycle 2 -> i_gnt@0, m_req@0 with m_addr=0x100, i_rvalid@2 with i_rdata=0x00000013, next i_gnt@3.
2. i_req and d_req both high at cycle 0, d_we=0, d_addr=0x400 -> d_gnt@0, i_gnt@3, d_rvalid@2, i_rvalid@5.
3. Store d_we=1, d_addr=0x404, d_wdata=0xDEADBEEF -> m_req=1, m_we=1, m_addr=0x404, m_wdata=0xDEADBEEF@0; d_rvalid ack@2; i_rvalid never.
4. d_req and i_req held continuously with MAX_D_STREAK=4 -> grant order D,D,D,D,I,D..., with grants spaced 3 cycles apart.
5. Reset asserted in cycle 1 of a D access -> no d_rvalid, busy=0@2, fresh i_req granted @2 if reset is deasserted.
6. MEM_LATENCY=1 back-to-back fetches -> grants @0,2,4; rvalid @1,3,5. With MEM_ARB_STATS_EN: stat_i_grants=3, stat_i_wait=2 after cycle 5.
